// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, arbiter state encoding and bus widths.
package sdram_pkg;

    localparam int CMD_W  = 4;
    localparam int BANK_W = 2;
    localparam int ADDR_W = 13;
    localparam int N_GRANT = 3;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

    localparam logic [BANK_W-1:0] BANK_IDLE = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_IDLE = 13'h1FFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    // Grant index 0/1/2 = refresh/write/read, also the priority order.
    function automatic state_t grant_state(input int idx);
        case (idx)
            0:       return ST_AREF;
            1:       return ST_WRITE;
            default: return ST_READ;
        endcase
    endfunction

endpackage

// File: rtl/sdram_arbit_mux.sv
// Combinational SDRAM bus mux: selects the owning stage's command/bank/address and DQ drive from the arbiter state.
module sdram_arbit_mux
    import sdram_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  state_t              state,
    input  logic [CMD_W-1:0]    init_cmd,
    input  logic [BANK_W-1:0]   init_bank,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [CMD_W-1:0]    ar_cmd,
    input  logic [BANK_W-1:0]   ar_bank,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic [CMD_W-1:0]    wr_cmd,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_sdram_en,
    input  logic [CMD_W-1:0]    rd_cmd,
    input  logic [BANK_W-1:0]   rd_bank,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CMD_W-1:0]    sdram_cmd,
    output logic [BANK_W-1:0]   sdram_bank,
    output logic [ADDR_W-1:0]   sdram_addr,
    output logic [DATA_W-1:0]   sdram_dq_out,
    output logic                sdram_dq_oe
);

    always_comb begin
        sdram_cmd    = CMD_NOP;
        sdram_bank   = BANK_IDLE;
        sdram_addr   = ADDR_IDLE;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        case (state)
            ST_IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ar_cmd;
                sdram_bank = ar_bank;
                sdram_addr = ar_addr;
            end
            ST_WRITE: begin
                sdram_cmd    = wr_cmd;
                sdram_bank   = wr_bank;
                sdram_addr   = wr_addr;
                sdram_dq_out = wr_data;
                sdram_dq_oe  = wr_sdram_en;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: after init, grants refresh > write > read, one stage at a time, with a NOP cycle between grants.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                arb_clk,
    input  logic                arb_rst,
    input  logic [CMD_W-1:0]    init_cmd,
    input  logic [BANK_W-1:0]   init_bank,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic                init_end,
    input  logic                ar_req,
    input  logic                ar_end,
    input  logic [CMD_W-1:0]    ar_cmd,
    input  logic [BANK_W-1:0]   ar_bank,
    input  logic [ADDR_W-1:0]   ar_addr,
    output logic                ar_en,
    input  logic                wr_req,
    input  logic                wr_end,
    input  logic [CMD_W-1:0]    wr_cmd,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_sdram_en,
    output logic                wr_en,
    input  logic                rd_req,
    input  logic                rd_end,
    input  logic [CMD_W-1:0]    rd_cmd,
    input  logic [BANK_W-1:0]   rd_bank,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_en,
    output logic                sdram_cke,
    output logic [CMD_W-1:0]    sdram_cmd,
    output logic [BANK_W-1:0]   sdram_bank,
    output logic [ADDR_W-1:0]   sdram_addr,
    output logic [DATA_W-1:0]   sdram_dq_out,
    output logic                sdram_dq_oe
);

    state_t               state_reg, state_next;
    logic                 cke_reg;
    logic [N_GRANT-1:0]   grant_vec;

    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state_reg <= ST_IDLE;
            cke_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cke_reg   <= 1'b1;
        end
    end

    // Requests are only looked at in ARBIT; an active grant runs until its own end pulse.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (init_end) state_next = ST_ARBIT;
            ST_ARBIT: begin
                if (ar_req)      state_next = ST_AREF;
                else if (wr_req) state_next = ST_WRITE;
                else if (rd_req) state_next = ST_READ;
            end
            ST_AREF:  if (ar_end) state_next = ST_ARBIT;
            ST_WRITE: if (wr_end) state_next = ST_ARBIT;
            ST_READ:  if (rd_end) state_next = ST_ARBIT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Enables register the next state so each is high exactly while its state is current.
    for (genvar gi = 0; gi < N_GRANT; gi++) begin : g_grant
        logic grant_reg;
        always_ff @(posedge arb_clk) begin
            if (arb_rst) grant_reg <= 1'b0;
            else         grant_reg <= (state_next == grant_state(gi));
        end
        assign grant_vec[gi] = grant_reg;
    end

    assign ar_en     = grant_vec[0];
    assign wr_en     = grant_vec[1];
    assign rd_en     = grant_vec[2];
    assign sdram_cke = cke_reg;

    sdram_arbit_mux #(.DATA_W(DATA_W)) u_mux (
        .state        (state_reg),
        .init_cmd     (init_cmd),
        .init_bank    (init_bank),
        .init_addr    (init_addr),
        .ar_cmd       (ar_cmd),
        .ar_bank      (ar_bank),
        .ar_addr      (ar_addr),
        .wr_cmd       (wr_cmd),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_sdram_en  (wr_sdram_en),
        .rd_cmd       (rd_cmd),
        .rd_bank      (rd_bank),
        .rd_addr      (rd_addr),
        .sdram_cmd    (sdram_cmd),
        .sdram_bank   (sdram_bank),
        .sdram_addr   (sdram_addr),
        .sdram_dq_out (sdram_dq_out),
        .sdram_dq_oe  (sdram_dq_oe)
    );

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: a bus-ownership model queues expected outputs, a negedge monitor compares them.
module tb_sdram_arbit;

    localparam int DATA_W = 16;

    // Bus owner in the model: 0/1/2 = refresh/write/read stage, then free (arbitrating) and init.
    localparam int OWN_FREE = 3;
    localparam int OWN_INIT = 4;

    logic              arb_clk = 1'b0;
    logic              arb_rst = 1'b0;
    logic [3:0]        init_cmd = '0, ar_cmd = '0, wr_cmd = '0, rd_cmd = '0;
    logic [1:0]        init_bank = '0, ar_bank = '0, wr_bank = '0, rd_bank = '0;
    logic [12:0]       init_addr = '0, ar_addr = '0, wr_addr = '0, rd_addr = '0;
    logic              init_end = 1'b0;
    logic              ar_req = 1'b0, ar_end = 1'b0, wr_req = 1'b0, wr_end = 1'b0;
    logic              rd_req = 1'b0, rd_end = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_sdram_en = 1'b0;
    logic              ar_en, wr_en, rd_en, sdram_cke, sdram_dq_oe;
    logic [3:0]        sdram_cmd;
    logic [1:0]        sdram_bank;
    logic [12:0]       sdram_addr;
    logic [DATA_W-1:0] sdram_dq_out;

    sdram_arbit #(.DATA_W(DATA_W)) dut (
        .arb_clk(arb_clk), .arb_rst(arb_rst),
        .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr), .init_end(init_end),
        .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr), .ar_en(ar_en),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_sdram_en(wr_sdram_en), .wr_en(wr_en),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 arb_clk = ~arb_clk;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [1:0]        bank;
        logic [12:0]       addr;
        logic [2:0]        en;
        logic              cke;
        logic [DATA_W-1:0] dq_out;
        logic              dq_oe;
    } exp_t;

    exp_t exp_q[$];
    int   owner = OWN_INIT;
    logic cke_m = 1'b0;
    bit   model_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL txn=%0d %s: got %h expected %h", txn, name, act, req);
        end
    endtask

    // Expected outputs for the current cycle: owner after the previous edge, buses as driven now.
    function automatic exp_t expected();
        exp_t e;
        e.cke    = cke_m;
        e.en     = (owner < 3) ? (3'b001 << owner) : 3'b000;
        e.dq_oe  = (owner == 1) ? wr_sdram_en : 1'b0;
        e.dq_out = (owner == 1) ? wr_data : '0;
        case (owner)
            OWN_INIT: begin e.cmd = init_cmd; e.bank = init_bank; e.addr = init_addr; end
            0:        begin e.cmd = ar_cmd;   e.bank = ar_bank;   e.addr = ar_addr;   end
            1:        begin e.cmd = wr_cmd;   e.bank = wr_bank;   e.addr = wr_addr;   end
            2:        begin e.cmd = rd_cmd;   e.bank = rd_bank;   e.addr = rd_addr;   end
            default:  begin e.cmd = 4'b0111;  e.bank = 2'b11;     e.addr = 13'h1FFF;  end
        endcase
        return e;
    endfunction

    // Ownership rules at a clock edge: init hands over once, free bus goes to the
    // highest-priority requester, a stage keeps the bus until its own done pulse.
    task automatic model_edge();
        logic [2:0] req;
        logic [2:0] fin;
        bit         found;
        req = {rd_req, wr_req, ar_req};
        fin = {rd_end, wr_end, ar_end};
        if (arb_rst) begin
            owner = OWN_INIT;
            cke_m = 1'b0;
            model_valid = 1'b1;
            return;
        end
        cke_m = 1'b1;
        if (owner == OWN_INIT) begin
            if (init_end) owner = OWN_FREE;
        end else if (owner == OWN_FREE) begin
            found = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!found && req[i]) begin
                    owner = i;
                    found = 1'b1;
                end
            end
        end else if (fin[owner]) begin
            owner = OWN_FREE;
        end
    endtask

    task automatic step();
        if (model_valid) exp_q.push_back(expected());
        @(posedge arb_clk);
        model_edge();
        #1;
    endtask

    task automatic rand_buses();
        init_cmd = 4'($urandom);  init_bank = 2'($urandom); init_addr = 13'($urandom);
        ar_cmd   = 4'($urandom);  ar_bank   = 2'($urandom); ar_addr   = 13'($urandom);
        wr_cmd   = 4'($urandom);  wr_bank   = 2'($urandom); wr_addr   = 13'($urandom);
        rd_cmd   = 4'($urandom);  rd_bank   = 2'($urandom); rd_addr   = 13'($urandom);
        wr_data  = DATA_W'($urandom);
        wr_sdram_en = 1'($urandom);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge arb_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                chk("sdram_cmd",    32'(sdram_cmd),              32'(e.cmd));
                chk("sdram_bank",   32'(sdram_bank),             32'(e.bank));
                chk("sdram_addr",   32'(sdram_addr),             32'(e.addr));
                chk("grants",       32'({rd_en, wr_en, ar_en}),  32'(e.en));
                chk("sdram_cke",    32'(sdram_cke),              32'(e.cke));
                chk("sdram_dq_out", 32'(sdram_dq_out),           32'(e.dq_out));
                chk("sdram_dq_oe",  32'(sdram_dq_oe),            32'(e.dq_oe));
                $display("txn %0d: cmd=%b bank=%b addr=%h en(rd,wr,ar)=%b cke=%b oe=%b dq=%h",
                         txn, sdram_cmd, sdram_bank, sdram_addr, {rd_en, wr_en, ar_en},
                         sdram_cke, sdram_dq_oe, sdram_dq_out);
            end
        end
    end

    initial begin : stimulus
        // Reset, then idle in init with a PRE command on the init bus.
        arb_rst = 1'b1; step(); step();
        arb_rst = 1'b0; init_cmd = 4'b0010; step(); step(); step();
        // Init done, single refresh.
        init_end = 1'b1; step();
        ar_req = 1'b1; step();
        ar_req = 1'b0; step(); step();
        ar_end = 1'b1; step();
        ar_end = 1'b0; step();
        // All three request together: refresh, then write, then read.
        ar_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1; step();
        ar_req = 1'b0; step();
        ar_end = 1'b1; step();
        ar_end = 1'b0; step();
        wr_req = 1'b0; wr_sdram_en = 1'b1; wr_data = 16'hA5A5; step();
        // Refresh request and stray end pulses during the write must not pre-empt it.
        ar_req = 1'b1; rd_end = 1'b1; ar_end = 1'b1; step();
        rd_end = 1'b0; ar_end = 1'b0; step();
        wr_end = 1'b1; ar_req = 1'b1; step();
        wr_end = 1'b0; step();
        ar_req = 1'b0; ar_end = 1'b1; step();
        ar_end = 1'b0; step();
        rd_req = 1'b0; step(); step();
        // Reset in the middle of the read, with init_end still high.
        arb_rst = 1'b1; init_cmd = 4'b0000; step();
        arb_rst = 1'b0; init_end = 1'b0; step(); step();
        init_end = 1'b1; step();

        // Random traffic, including stray end pulses, init_end dropping and occasional resets.
        for (int n = 0; n < 2000; n++) begin
            rand_buses();
            arb_rst  = ($urandom_range(99) < 2);
            init_end = ($urandom_range(9) < 7);
            ar_req   = ($urandom_range(9) < 2);
            wr_req   = ($urandom_range(9) < 4);
            rd_req   = ($urandom_range(9) < 4);
            ar_end   = ($urandom_range(3) == 0);
            wr_end   = ($urandom_range(3) == 0);
            rd_end   = ($urandom_range(3) == 0);
            step();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge arb_clk);
        @(posedge arb_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
